dmem_arbiter: RTL and testbench

//   Two-master arbiter in front of the single-port data memory (14-bit byte address, 32-bit data).

---
 rtl/dmem_arbiter.sv | 128 ++++++++++++
 tb/tb_dmem_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data memory: round-robin with bounded hold,
// misaligned accesses are consumed but never reach the memory, read data is steered by an owner tag.
module dmem_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int DEF_MSTR = 0
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        m0_req,
    input  logic [2:0]  m0_op,
    input  logic [13:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic [2:0]  m1_op,
    input  logic [13:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [2:0]  mem_op_code,
    output logic [13:0] mem_rwaddr,
    output logic [31:0] mem_wdata,
    output logic        mem_stall,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rvalid_q, rtag_q;
    logic            err0_q, err1_q;

    logic            any_req;
    logic            sel1;
    logic            hold_full;
    logic [2:0]      sel_op;
    logic [13:0]     sel_addr;
    logic [31:0]     sel_wdata;
    logic            aligned;
    logic            issue;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel1      = 1'b0;
        any_req   = m0_req | m1_req;
        hold_full = (cnt_q >= HOLD_MAX);

        // sel1 picks M1; only meaningful while any_req is set
        if (m0_req && m1_req) begin
            case (state_q)
                OWN0:    sel1 = hold_full;
                OWN1:    sel1 = !hold_full;
                default: sel1 = (DEF_MSTR != 0);
            endcase
        end else begin
            sel1 = m1_req;
        end

        if (!any_req) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            state_d = sel1 ? OWN1 : OWN0;
            if (state_d == state_q)
                cnt_d = hold_full ? cnt_q : cnt_q + CW'(1);
            else
                cnt_d = CW'(1);
        end
    end

    // Grants are suppressed while reset is asserted so nothing is accepted then.
    assign m0_gnt = nrst && any_req && !sel1;
    assign m1_gnt = nrst && any_req && sel1;

    assign sel_op    = sel1 ? m1_op    : m0_op;
    assign sel_addr  = sel1 ? m1_addr  : m0_addr;
    assign sel_wdata = sel1 ? m1_wdata : m0_wdata;

    always_comb begin
        aligned = 1'b1;
        if (sel_op[1])
            aligned = (sel_addr[1:0] == 2'b00);
        else if (sel_op[0])
            aligned = !sel_addr[0];
    end

    assign issue       = (m0_gnt || m1_gnt) && aligned;
    assign mem_stall   = !issue;
    assign mem_op_code = issue ? sel_op    : 3'b0;
    assign mem_rwaddr  = issue ? sel_addr  : 14'b0;
    assign mem_wdata   = issue ? sel_wdata : 32'b0;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rtag_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= issue && !sel_op[2];
            rtag_q   <= sel1;
            err0_q   <= m0_gnt && !aligned;
            err1_q   <= m1_gnt && !aligned;
        end
    end

    assign m0_rvalid = rvalid_q && !rtag_q;
    assign m1_rvalid = rvalid_q && rtag_q;
    assign m0_rdata  = m0_rvalid ? mem_rdata : 32'b0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : 32'b0;
    assign m0_err    = err0_q;
    assign m1_err    = err1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: behavioural memory, per-cycle scoreboard of expected
// registered responses, and a second instance with DEF_MSTR=1 for the tie-break from IDLE.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        nrst;
    logic        m0_req, m1_req;
    logic [2:0]  m0_op, m1_op;
    logic [13:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [2:0]  mem_op_code;
    logic [13:0] mem_rwaddr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_stall;

    logic        d1_m0_gnt, d1_m0_rvalid, d1_m0_err, d1_m1_gnt, d1_m1_rvalid, d1_m1_err;
    logic [31:0] d1_m0_rdata, d1_m1_rdata, d1_mem_wdata;
    logic [2:0]  d1_mem_op_code;
    logic [13:0] d1_mem_rwaddr;
    logic        d1_mem_stall;

    typedef struct {
        logic        rv0;
        logic        rv1;
        logic        err0;
        logic        err1;
        logic [31:0] rd;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mem [0:4095];

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_HOLD(4), .DEF_MSTR(0)) dut (
        .clk(clk), .nrst(nrst),
        .m0_req(m0_req), .m0_op(m0_op), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_op(m1_op), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_op_code(mem_op_code), .mem_rwaddr(mem_rwaddr), .mem_wdata(mem_wdata),
        .mem_stall(mem_stall), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.MAX_HOLD(4), .DEF_MSTR(1)) dut1 (
        .clk(clk), .nrst(nrst),
        .m0_req(m0_req), .m0_op(m0_op), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(d1_m0_gnt), .m0_rvalid(d1_m0_rvalid), .m0_rdata(d1_m0_rdata), .m0_err(d1_m0_err),
        .m1_req(m1_req), .m1_op(m1_op), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(d1_m1_gnt), .m1_rvalid(d1_m1_rvalid), .m1_rdata(d1_m1_rdata), .m1_err(d1_m1_err),
        .mem_op_code(d1_mem_op_code), .mem_rwaddr(d1_mem_rwaddr), .mem_wdata(d1_mem_wdata),
        .mem_stall(d1_mem_stall), .mem_rdata(mem_rdata)
    );

    // Behavioural single-port memory with one-cycle registered read.
    always @(posedge clk) begin
        if (!mem_stall) begin
            if (mem_op_code[2]) begin
                if (mem_op_code[1])
                    mem[mem_rwaddr[13:2]] <= mem_wdata;
                else if (mem_op_code[0])
                    mem[mem_rwaddr[13:2]][{mem_rwaddr[1], 4'b0} +: 16] <= mem_wdata[15:0];
                else
                    mem[mem_rwaddr[13:2]][{mem_rwaddr[1:0], 3'b0} +: 8] <= mem_wdata[7:0];
            end else begin
                mem_rdata <= mem[mem_rwaddr[13:2]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic r0, input logic [2:0] o0, input logic [13:0] a0, input logic [31:0] w0,
                          input logic r1, input logic [2:0] o1, input logic [13:0] a1, input logic [31:0] w1);
        m0_req = r0; m0_op = o0; m0_addr = a0; m0_wdata = w0;
        m1_req = r1; m1_op = o1; m1_addr = a1; m1_wdata = w1;
    endtask

    // Called at a falling edge with inputs already driven. g: 0 none, 1 M0, 2 M1.
    task automatic cyc(input string tag, input int g, input logic stall, input logic [31:0] rd);
        exp_t e;
        #1;
        chk({tag, ":m0_gnt"}, 32'(m0_gnt), 32'(g == 1));
        chk({tag, ":m1_gnt"}, 32'(m1_gnt), 32'(g == 2));
        chk({tag, ":mem_stall"}, 32'(mem_stall), 32'(stall));
        e = '{rv0: 1'b0, rv1: 1'b0, err0: 1'b0, err1: 1'b0, rd: 32'h0};
        if (!stall) begin
            chk({tag, ":mem_addr"}, 32'(mem_rwaddr), (g == 1) ? 32'(m0_addr) : 32'(m1_addr));
            chk({tag, ":mem_op"}, 32'(mem_op_code), (g == 1) ? 32'(m0_op) : 32'(m1_op));
            if (mem_op_code[2])
                chk({tag, ":mem_wdata"}, mem_wdata, (g == 1) ? m0_wdata : m1_wdata);
            else if (g == 1) begin
                e.rv0 = 1'b1; e.rd = rd;
            end else begin
                e.rv1 = 1'b1; e.rd = rd;
            end
        end else begin
            chk({tag, ":mem_op_idle"}, 32'(mem_op_code), 32'h0);
            e.err0 = (g == 1);
            e.err1 = (g == 2);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ":m0_rvalid"}, 32'(m0_rvalid), 32'(e.rv0));
        chk({tag, ":m1_rvalid"}, 32'(m1_rvalid), 32'(e.rv1));
        chk({tag, ":m0_err"}, 32'(m0_err), 32'(e.err0));
        chk({tag, ":m1_err"}, 32'(m1_err), 32'(e.err1));
        chk({tag, ":m0_rdata"}, m0_rdata, e.rv0 ? e.rd : 32'h0);
        chk({tag, ":m1_rdata"}, m1_rdata, e.rv1 ? e.rd : 32'h0);
        $display("[TB] %s grant=%0d stall=%0b rv0=%0b rv1=%0b err0=%0b err1=%0b", tag, g, stall,
                 m0_rvalid, m1_rvalid, m0_err, m1_err);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
        mem_rdata = 32'h0;
        nrst = 1'b0;
        set_in(1'b1, 3'b010, 14'h0100, 32'h0, 1'b1, 3'b010, 14'h0200, 32'h0);
        @(negedge clk);
        #1;
        chk("rst:m0_gnt", 32'(m0_gnt), 32'h0);
        chk("rst:m1_gnt", 32'(m1_gnt), 32'h0);
        chk("rst:mem_stall", 32'(mem_stall), 32'h1);
        chk("rst:mem_op", 32'(mem_op_code), 32'h0);
        chk("rst:mem_addr", 32'(mem_rwaddr), 32'h0);
        chk("rst:rvalid", 32'({m0_rvalid, m1_rvalid, m0_err, m1_err}), 32'h0);
        set_in(1'b0, 3'b0, 14'h0, 32'h0, 1'b0, 3'b0, 14'h0, 32'h0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        // Solo M0: word write then read of the same word
        set_in(1'b1, 3'b111, 14'h07FC, 32'h0000_0001, 1'b0, 3'b0, 14'h0, 32'h0);
        cyc("solo_wr", 1, 1'b0, 32'h0);
        set_in(1'b1, 3'b010, 14'h07FC, 32'h0, 1'b0, 3'b0, 14'h0, 32'h0);
        cyc("solo_rd", 1, 1'b0, 32'h0000_0001);
        set_in(1'b0, 3'b0, 14'h0, 32'h0, 1'b0, 3'b0, 14'h0, 32'h0);
        cyc("idle", 0, 1'b1, 32'h0);

        // Both requesting continuously: bounded hold, and DEF_MSTR=1 instance picks M1 from IDLE
        set_in(1'b1, 3'b010, 14'h0100, 32'h0, 1'b1, 3'b010, 14'h0200, 32'h0);
        #1;
        chk("def1:m1_gnt", 32'(d1_m1_gnt), 32'h1);
        chk("def1:m0_gnt", 32'(d1_m0_gnt), 32'h0);
        for (int i = 0; i < 12; i++) begin
            if (((i / 4) % 2) == 0)
                cyc("hold", 1, 1'b0, 32'hA5A5_0040);
            else
                cyc("hold", 2, 1'b0, 32'hA5A5_0080);
        end
        set_in(1'b0, 3'b0, 14'h0, 32'h0, 1'b0, 3'b0, 14'h0, 32'h0);
        cyc("idle2", 0, 1'b1, 32'h0);

        // Misaligned half write from M1 must not touch memory
        set_in(1'b0, 3'b0, 14'h0, 32'h0, 1'b1, 3'b101, 14'h1BF9, 32'hDEAD_BEEF);
        cyc("mis_hw", 2, 1'b1, 32'h0);
        set_in(1'b0, 3'b0, 14'h0, 32'h0, 1'b1, 3'b010, 14'h1BF8, 32'h0);
        cyc("mis_rd", 2, 1'b0, 32'hA5A5_06FE);

        // Alignment boundaries on M0
        set_in(1'b1, 3'b000, 14'h0101, 32'h0, 1'b0, 3'b0, 14'h0, 32'h0);
        cyc("byte_odd", 1, 1'b0, 32'hA5A5_0040);
        set_in(1'b1, 3'b010, 14'h0102, 32'h0, 1'b0, 3'b0, 14'h0, 32'h0);
        cyc("word_mis", 1, 1'b1, 32'h0);
        set_in(1'b1, 3'b001, 14'h0102, 32'h0, 1'b0, 3'b0, 14'h0, 32'h0);
        cyc("half_ok", 1, 1'b0, 32'hA5A5_0040);

        // Alternating reads on consecutive cycles
        set_in(1'b1, 3'b010, 14'h0100, 32'h0, 1'b0, 3'b0, 14'h0, 32'h0);
        cyc("alt_m0", 1, 1'b0, 32'hA5A5_0040);
        set_in(1'b0, 3'b0, 14'h0, 32'h0, 1'b1, 3'b010, 14'h0200, 32'h0);
        cyc("alt_m1", 2, 1'b0, 32'hA5A5_0080);

        // Reset right after an M1 read is issued: no rvalid, back to IDLE
        set_in(1'b0, 3'b0, 14'h0, 32'h0, 1'b1, 3'b010, 14'h0200, 32'h0);
        #1;
        chk("rst_mid:pre_gnt", 32'(m1_gnt), 32'h1);
        @(posedge clk);
        #1;
        nrst = 1'b0;
        #1;
        chk("rst_mid:m1_rvalid", 32'(m1_rvalid), 32'h0);
        chk("rst_mid:m1_rdata", m1_rdata, 32'h0);
        chk("rst_mid:m1_gnt", 32'(m1_gnt), 32'h0);
        chk("rst_mid:mem_stall", 32'(mem_stall), 32'h1);
        chk("rst_mid:err", 32'({m0_err, m1_err, m0_rvalid}), 32'h0);
        $display("[TB] rst_mid rvalid=%0b stall=%0b", m1_rvalid, mem_stall);
        @(negedge clk);
        set_in(1'b0, 3'b0, 14'h0, 32'h0, 1'b0, 3'b0, 14'h0, 32'h0);
        nrst = 1'b1;
        @(negedge clk);
        set_in(1'b1, 3'b010, 14'h0100, 32'h0, 1'b1, 3'b010, 14'h0200, 32'h0);
        cyc("post_rst", 1, 1'b0, 32'hA5A5_0040);
        set_in(1'b0, 3'b0, 14'h0, 32'h0, 1'b0, 3'b0, 14'h0, 32'h0);
        cyc("idle3", 0, 1'b1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
